// File: rtl/telemetry_pkg.sv
// Shared types for the telemetry framer: FSM states, packet length and the sample record.
// The packet length depends on TELEMETRY_CHECKSUM_EN: 6 bytes when defined, 5 bytes otherwise.
package telemetry_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND      = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_IDLE = 3'd4
    } framer_state_t;

`ifdef TELEMETRY_CHECKSUM_EN
    localparam int unsigned PKT_LEN = 6;
`else
    localparam int unsigned PKT_LEN = 5;
`endif

    typedef struct packed {
        logic [15:0] angle;
        logic [15:0] mag;
    } telemetry_sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO of telemetry samples; an extra pointer bit separates full from empty.
module sample_fifo
    import telemetry_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  telemetry_sample_t wdata,
    output telemetry_sample_t rdata,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    telemetry_sample_t mem_q [DEPTH];

    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, push};
        rptr_d = rptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/telemetry_framer.sv
// Buffers telemetry samples and frames each one into a byte packet for the UART handshake.
// Define TELEMETRY_CHECKSUM_EN to append a modulo-256 payload checksum byte.
module telemetry_framer
    import telemetry_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample_angle,
    input  logic [15:0] sample_mag,
    input  logic        tx_busy,
    output logic        data_rdy,
    output logic [7:0]  data,
    output logic        fifo_full,
    output logic [7:0]  drop_count,
    output logic        framer_busy
);

    localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

    framer_state_t     state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    telemetry_sample_t pkt_q, pkt_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        drop_q, drop_d;

    telemetry_sample_t fifo_head;
    logic              fifo_empty;
    logic              push, pop;

    function automatic logic [7:0] pkt_byte(telemetry_sample_t s, logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = HEADER;
            3'd1:    b = s.angle[15:8];
            3'd2:    b = s.angle[7:0];
            3'd3:    b = s.mag[15:8];
            3'd4:    b = s.mag[7:0];
`ifdef TELEMETRY_CHECKSUM_EN
            3'd5:    b = s.angle[15:8] + s.angle[7:0] + s.mag[15:8] + s.mag[7:0];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign pop  = (state_q == LOAD);
    // A full FIFO still accepts a sample in the cycle its head is popped.
    assign push = sample_valid && (!fifo_full || pop);

    sample_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .wdata('{angle: sample_angle, mag: sample_mag}),
        .rdata(fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pkt_d   = pkt_q;
        data_d  = data_q;
        drop_d  = drop_q;

        if (sample_valid && fifo_full && !pop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                // Looking at the incoming strobe saves a cycle of first-byte latency.
                if ((!fifo_empty || sample_valid) && !tx_busy) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pkt_d   = fifo_head;
                idx_d   = 3'd0;
                data_d  = HEADER;
                state_d = SEND;
            end
            SEND: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        data_d  = pkt_byte(pkt_q, idx_q + 3'd1);
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            pkt_q   <= '0;
            data_q  <= 8'h00;
            drop_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pkt_q   <= pkt_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign data_rdy    = (state_q == SEND);
    assign data        = data_q;
    assign drop_count  = drop_q;
    assign framer_busy = (state_q != IDLE);

endmodule
